// File: rtl/fft_sample_capture_if.sv
// Sample-capture bus: ADC SPI pins, sample RAM write port and frame status.
// The capture block drives it through the master modport.
interface fft_sample_capture_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
);
   logic              Arm;
   logic              Adc_sdata;
   logic              Adc_cs_n;
   logic              Adc_sclk;
   logic              Wr_en;
   logic [ADDR_W-1:0] Wr_addr;
   logic [DATA_W-1:0] Wr_data;
   logic              Busy;
   logic              Frame_done;

   modport master (
      input  Arm, Adc_sdata,
      output Adc_cs_n, Adc_sclk, Wr_en, Wr_addr, Wr_data,
      output Busy, Frame_done
   );

   modport slave (
      output Arm, Adc_sdata,
      input  Adc_cs_n, Adc_sclk, Wr_en, Wr_addr, Wr_data,
      input  Busy, Frame_done
   );
endinterface

// File: rtl/fft_sample_capture.sv
// SPI master for an AD7476-style 12-bit ADC.
// Captures one frame of equally spaced samples into the FFT sample RAM.
module fft_sample_capture #(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 2268,
   parameter int N_SAMPLES     = 256,
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 12
) (
   input  logic Clk,
   input  logic Reset,
   fft_sample_capture_if.master bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PER_W = $clog2(SAMPLE_PERIOD);

   localparam logic [DIV_W-1:0]  DIV_END = DIV_W'(CLK_DIV - 1);
   localparam logic [PER_W-1:0]  PER_END = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [ADDR_W-1:0] IDX_END = ADDR_W'(N_SAMPLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [4:0]        half_cnt;
   logic [PER_W-1:0]  per_cnt;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] shreg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state          <= S_IDLE;
         div_cnt        <= '0;
         half_cnt       <= '0;
         per_cnt        <= '0;
         idx            <= '0;
         shreg          <= '0;
         bus.Adc_cs_n   <= 1'b1;
         bus.Adc_sclk   <= 1'b1;
         bus.Wr_en      <= 1'b0;
         bus.Wr_addr    <= '0;
         bus.Wr_data    <= '0;
         bus.Busy       <= 1'b0;
         bus.Frame_done <= 1'b0;
      end else begin
         bus.Wr_en      <= 1'b0;
         bus.Frame_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.Arm) begin
                  state        <= S_CONV;
                  idx          <= '0;
                  per_cnt      <= '0;
                  div_cnt      <= '0;
                  half_cnt     <= '0;
                  bus.Adc_cs_n <= 1'b0;
                  bus.Adc_sclk <= 1'b0;
                  bus.Busy     <= 1'b1;
               end
            end
            S_CONV: begin
               // per_cnt keeps counting from CS fall so spacing ignores write timing
               per_cnt <= per_cnt + 1'b1;
               if (div_cnt == DIV_END) begin
                  div_cnt  <= '0;
                  half_cnt <= half_cnt + 1'b1;
                  if (half_cnt == 5'd31) begin
                     bus.Adc_cs_n <= 1'b1;
                     bus.Adc_sclk <= 1'b1;
                     bus.Wr_en    <= 1'b1;
                     bus.Wr_addr  <= idx;
                     bus.Wr_data  <= shreg;
                     if (idx == IDX_END) begin
                        state <= S_DONE;
                     end else begin
                        state <= S_WAIT;
                        idx   <= idx + 1'b1;
                     end
                  end else begin
                     bus.Adc_sclk <= ~bus.Adc_sclk;
                     // 16 shifts through a 12-bit register drop the leading nibble
                     if (!bus.Adc_sclk) begin
                        shreg <= {shreg[DATA_W-2:0], bus.Adc_sdata};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (per_cnt == PER_END) begin
                  state        <= S_CONV;
                  per_cnt      <= '0;
                  div_cnt      <= '0;
                  half_cnt     <= '0;
                  bus.Adc_cs_n <= 1'b0;
                  bus.Adc_sclk <= 1'b0;
               end else begin
                  per_cnt <= per_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state          <= S_IDLE;
               bus.Busy       <= 1'b0;
               bus.Frame_done <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
